// File: rtl/argmax_pkg.sv
// Shared types and constants for the streaming argmax front-end.
package argmax_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned MAX_IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Frame result as presented downstream; idx sized for the largest legal frame.
    typedef struct packed {
        logic [DATA_W-1:0]    max;
        logic [MAX_IDX_W-1:0] idx;
    } result_t;

    // Index width for a frame of n samples; a single-sample frame still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        if (n > 1) begin
            return int'($clog2(n));
        end
        return 1;
    endfunction

endpackage

// File: rtl/cmp.sv
// Library two-input unsigned comparator: lower when num0 < num1, res is the larger operand.
module cmp
    import argmax_pkg::*;
(
    input  logic [DATA_W-1:0] num0,
    input  logic [DATA_W-1:0] num1,
    output logic              lower,
    output logic [DATA_W-1:0] res
);

    assign lower = (num0 < num1);
    assign res   = lower ? num1 : num0;

endmodule

// File: rtl/argmax_stream.sv
// Frame-based streaming argmax: accepts N samples, then holds {max, index} until taken.
module argmax_stream
    import argmax_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [IDX_W-1:0]  run_idx_q, run_idx_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_max_q, out_max_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;

    logic              cmp_lower;
    logic [DATA_W-1:0] cmp_res;
    logic              in_xfer;
    logic              out_xfer;

    cmp u_cmp (
        .num0  (run_max_q),
        .num1  (in_data),
        .lower (cmp_lower),
        .res   (cmp_res)
    );

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Next-state and datapath; ready/valid are registered from the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;

        unique case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    run_max_d = in_data;
                    run_idx_d = '0;
                    cnt_d     = CNT_W'(1);
                    state_d   = (N == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_xfer) begin
                    // Strict greater-than only: ties keep the earlier index.
                    if (cmp_lower) begin
                        run_max_d = cmp_res;
                        run_idx_d = cnt_q[IDX_W-1:0];
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_xfer) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d != DONE);
        out_valid_d = (state_d == DONE);
        out_max_d   = (state_d == DONE) ? run_max_d : out_max_q;
        out_idx_d   = (state_d == DONE) ? run_idx_d : out_idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            run_max_q   <= '0;
            run_idx_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_max_q   <= out_max_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_idx   = out_idx_q;

endmodule
